tx_fc_arbiter_scheduler: RTL and testbench
==========================================

Name: tx_fc_arbiter_scheduler

Overview:
- Tx-side scheduler that shares the link among three TLP sources: Posted (P), Non-Posted (NP) and Completion (CPL).
- Each round it snapshots the pending requests in round-robin order. It offers the top two candidates to the flow-control checker through the ARBITER_FC side of Tx_FC_Interface.
- It grants the source the FC checker approves, and pulses a credit-consume update to the checker.
- It holds the grant until the winning source signals end of TLP.
- A starvation limiter stops the second candidate from bypassing the first indefinitely.

Parameters:
- PTLP_WIDTH, 10, payload length field width in DW (matches FC PTLP fields).
- STARVE_LIMIT, 4, number of consecutive candidate-2 wins before candidate 2 is suppressed.
- STARVE_CNT_WIDTH, $clog2(STARVE_LIMIT+1), starvation counter width.

Ports:
- clk  in  1  single Tx clock.
- arst  in  1  asynchronous, active-low reset.
- req_i  in  3  request per source; index 0 = P, 1 = NP, 2 = CPL; held high until granted.
- len_p_i / len_np_i / len_cpl_i  in  PTLP_WIDTH each  payload length of the pending TLP; stable while req is high.
- done_i  in  3  one-cycle end-of-TLP strobe per source.
- grant_o  out  3  one-hot grant, held for the whole TLP.
- fc_command_1_o  out  FC_command_t  candidate 1 type.
- fc_ptlp_1_o  out  PTLP_WIDTH  candidate 1 payload length.
- fc_command_2_o  out  FC_command_t  candidate 2 type.
- fc_ptlp_2_o  out  PTLP_WIDTH  candidate 2 payload length.
- fc_result_i  in  FC_result_t  combinational verdict from FC: FC_FAILED, FC_SUCCESS_1 or FC_SUCCESS_2.
- fc_update_o  out  1  one-cycle credit-consume pulse.
- fc_update_cmd_o  out  FC_command_t  type to debit.
- fc_update_ptlp_o  out  PTLP_WIDTH  length to debit.
- busy_o  out  1  high when not in IDLE.

Behaviour:
- Reset (arst=0, asynchronous; takes effect mid-operation too): state=IDLE, grant_o=0, both commands=FC_NO_CMD, both ptlp=0, fc_update_o=0, fc_update_cmd_o=FC_NO_CMD, fc_update_ptlp_o=0, rr_ptr=P, starve_cnt=0, busy_o=0.
- Candidate order: rr_ptr, rr_ptr+1, rr_ptr+2, all mod 3.
  - cand1 = first requesting source in that order; cand2 = next requesting source.
  - An absent candidate drives FC_NO_CMD with ptlp 0.
- FC outputs are registered. They are loaded on IDLE->CHECK and reloaded every CHECK cycle that ends in FC_FAILED.
- States:
  - IDLE: if |req_i, load candidates and go to CHECK; otherwise stay in IDLE.
  - CHECK: sample fc_result_i at the clock edge.
    - FC_SUCCESS_1: winner=cand1; starve_cnt<=0.
    - FC_SUCCESS_2 with cand2 valid: winner=cand2; starve_cnt increments, saturating at STARVE_LIMIT.
    - FC_SUCCESS_2 with cand2 absent, or FC_FAILED: stay in CHECK, resnapshot; rr_ptr and starve_cnt unchanged.
    - On any win: go to XMIT; grant_o<=onehot(winner); commands<=FC_NO_CMD; pulse fc_update_o for exactly one cycle with the winner's command and length.
  - XMIT: hold grant_o. On done_i[winner]: rr_ptr<=winner+1 mod 3, go to IDLE; grant_o drops the next cycle. done_i bits for non-winners are ignored.
- Latency: req rises in cycle 0, commands valid in cycle 1, grant_o and fc_update_o high in cycle 2. The minimum gap between consecutive grants is 2 idle cycles (IDLE, CHECK).
- Starvation: while starve_cnt==STARVE_LIMIT, fc_command_2_o is forced to FC_NO_CMD and fc_ptlp_2_o to 0, until cand1 wins.
- req_i[winner] dropping in XMIT without done_i is a protocol violation; the FSM keeps waiting and the bench asserts on it.
- done_i arriving in the same cycle as the grant is accepted (single-cycle TLP).

Decomposition:
- Tx_Arbiter_Package holds:
  - FC_command_t: FC_P=2'b00, FC_NP=2'b01, FC_CPL=2'b10, FC_NO_CMD=2'b11.
  - FC_result_t: FC_FAILED=2'b00, FC_SUCCESS_1=2'b01, FC_SUCCESS_2=2'b10.
  - Source index constants.
  - tx_arb_state_t: IDLE, CHECK, XMIT.
- One natural sub-module, tx_rr_candidate_picker: combinational; takes req_i and rr_ptr, produces cand1/cand2 with valid flags.

Test Plan:
- Reset, then req_i=3'b111, FC returns SUCCESS_1 -> commands P/NP in cycle 1, grant_o=001 and fc_update_o with FC_P in cycle 2; done_i[0] -> next candidates are NP/CPL.
- Only CPL requests, len_cpl_i=10'd32, FC_SUCCESS_1 -> fc_command_2_o=FC_NO_CMD, grant_o=100, fc_update_ptlp_o=32.
- req P+NP, FC returns FC_FAILED for 3 cycles then SUCCESS_2 -> commands reloaded each cycle, grant_o=010, rr_ptr=CPL after done.
- P always requesting and always failing, NP winning via SUCCESS_2 four times -> fifth CHECK shows fc_command_2_o=FC_NO_CMD until P wins, then starve_cnt=0.
- arst asserted mid-XMIT with grant_o=100 -> grant_o=000 and rr_ptr=P immediately; next request resumes from P.
- SUCCESS_2 returned while only one source requests -> no grant; state stays CHECK.

Source files
------------

// File: rtl/tx_fc_arbiter_scheduler_pkg.sv
// Shared types and constants for the Tx flow-control arbiter scheduler.
// Contents:
//   FC_command_t   - TLP type presented to / debited from the FC checker
//   FC_result_t    - verdict returned by the FC checker
//   SRC_*          - source indices (0 = P, 1 = NP, 2 = CPL)
//   tx_arb_state_t - scheduler FSM state encoding
package tx_fc_arbiter_scheduler_pkg;

  typedef enum logic [1:0] {
    FC_P      = 2'b00,
    FC_NP     = 2'b01,
    FC_CPL    = 2'b10,
    FC_NO_CMD = 2'b11
  } FC_command_t;

  typedef enum logic [1:0] {
    FC_FAILED    = 2'b00,
    FC_SUCCESS_1 = 2'b01,
    FC_SUCCESS_2 = 2'b10
  } FC_result_t;

  localparam logic [1:0] SRC_P   = 2'd0;
  localparam logic [1:0] SRC_NP  = 2'd1;
  localparam logic [1:0] SRC_CPL = 2'd2;

  typedef logic [1:0] tx_arb_state_t;
  localparam tx_arb_state_t IDLE  = 2'd0;
  localparam tx_arb_state_t CHECK = 2'd1;
  localparam tx_arb_state_t XMIT  = 2'd2;

  // Next source in round-robin order, wrapping CPL back to P.
  function automatic logic [1:0] src_next(input logic [1:0] s);
    return (s == SRC_CPL) ? SRC_P : s + 2'd1;
  endfunction

  // Source index and command encodings coincide for the three real types.
  function automatic FC_command_t src_to_cmd(input logic [1:0] s);
    return FC_command_t'(s);
  endfunction

endpackage

// File: rtl/tx_fc_arbiter_scheduler_picker.sv
// Combinational round-robin candidate picker.
// Scans sources in the order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3) and returns the
// first and second requesting sources.
// Ports:
//   req_i       - request per source (0 = P, 1 = NP, 2 = CPL)
//   rr_ptr_i    - source with highest priority this round
//   cand1_o/_vld_o, cand2_o/_vld_o - candidate indices and presence flags
module tx_rr_candidate_picker
  import tx_fc_arbiter_scheduler_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] rr_ptr_i,
  output logic [1:0] cand1_o,
  output logic       cand1_vld_o,
  output logic [1:0] cand2_o,
  output logic       cand2_vld_o
);

  always_comb begin
    logic [1:0] s;
    cand1_o     = SRC_P;
    cand1_vld_o = 1'b0;
    cand2_o     = SRC_P;
    cand2_vld_o = 1'b0;
    s           = rr_ptr_i;
    for (int i = 0; i < 3; i++) begin
      if (req_i[s]) begin
        if (!cand1_vld_o) begin
          cand1_o     = s;
          cand1_vld_o = 1'b1;
        end else if (!cand2_vld_o) begin
          cand2_o     = s;
          cand2_vld_o = 1'b1;
        end
      end
      s = src_next(s);
    end
  end

endmodule

// File: rtl/tx_fc_arbiter_scheduler.sv
// Tx-side scheduler sharing the link among Posted, Non-Posted and Completion
// sources. Offers two round-robin candidates to the FC checker, grants the one
// it approves, pulses a credit-consume update and holds the grant until the
// winner signals end of TLP. A starvation limiter stops candidate 2 from
// overtaking candidate 1 more than STARVE_LIMIT times in a row.
// Ports:
//   clk, arst                      - clock, async active-low reset
//   req_i, len_*_i, done_i         - per-source request, payload length, end-of-TLP
//   grant_o                        - one-hot grant held for the whole TLP
//   fc_command_1/2_o, fc_ptlp_1/2_o - registered candidates offered to FC
//   fc_result_i                    - combinational FC verdict
//   fc_update_o/_cmd_o/_ptlp_o     - one-cycle credit-consume pulse
//   busy_o                         - FSM not in IDLE
module tx_fc_arbiter_scheduler
  import tx_fc_arbiter_scheduler_pkg::*;
#(
  parameter int unsigned PTLP_WIDTH       = 10,
  parameter int unsigned STARVE_LIMIT     = 4,
  parameter int unsigned STARVE_CNT_WIDTH = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [2:0]            req_i,
  input  logic [PTLP_WIDTH-1:0] len_p_i,
  input  logic [PTLP_WIDTH-1:0] len_np_i,
  input  logic [PTLP_WIDTH-1:0] len_cpl_i,
  input  logic [2:0]            done_i,
  output logic [2:0]            grant_o,
  output FC_command_t           fc_command_1_o,
  output logic [PTLP_WIDTH-1:0] fc_ptlp_1_o,
  output FC_command_t           fc_command_2_o,
  output logic [PTLP_WIDTH-1:0] fc_ptlp_2_o,
  input  FC_result_t            fc_result_i,
  output logic                  fc_update_o,
  output FC_command_t           fc_update_cmd_o,
  output logic [PTLP_WIDTH-1:0] fc_update_ptlp_o,
  output logic                  busy_o
);

  localparam logic [STARVE_CNT_WIDTH-1:0] StarveMax = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  tx_arb_state_t               state_q, state_d;
  logic [1:0]                  rr_ptr_q, rr_ptr_d;
  logic [1:0]                  winner_q, winner_d;
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
  logic [2:0]                  grant_q, grant_d;
  FC_command_t                 cmd1_q, cmd1_d, cmd2_q, cmd2_d;
  logic [PTLP_WIDTH-1:0]       ptlp1_q, ptlp1_d, ptlp2_q, ptlp2_d;
  logic                        upd_q, upd_d;
  FC_command_t                 upd_cmd_q, upd_cmd_d;
  logic [PTLP_WIDTH-1:0]       upd_ptlp_q, upd_ptlp_d;

  logic [1:0] cand1, cand2;
  logic       cand1_vld, cand2_vld;

  tx_rr_candidate_picker u_picker (
    .req_i       (req_i),
    .rr_ptr_i    (rr_ptr_q),
    .cand1_o     (cand1),
    .cand1_vld_o (cand1_vld),
    .cand2_o     (cand2),
    .cand2_vld_o (cand2_vld)
  );

  function automatic logic [PTLP_WIDTH-1:0] len_sel(input logic [1:0] s,
                                                    input logic [PTLP_WIDTH-1:0] lp,
                                                    input logic [PTLP_WIDTH-1:0] lnp,
                                                    input logic [PTLP_WIDTH-1:0] lcpl);
    case (s)
      SRC_P:   return lp;
      SRC_NP:  return lnp;
      default: return lcpl;
    endcase
  endfunction

  // Snapshot of the current candidates; candidate 2 is hidden while starved.
  FC_command_t           snap_cmd1, snap_cmd2;
  logic [PTLP_WIDTH-1:0] snap_ptlp1, snap_ptlp2;
  logic                  starved;

  always_comb begin
    starved    = (starve_cnt_q == StarveMax);
    snap_cmd1  = cand1_vld ? src_to_cmd(cand1) : FC_NO_CMD;
    snap_ptlp1 = cand1_vld ? len_sel(cand1, len_p_i, len_np_i, len_cpl_i) : '0;
    snap_cmd2  = (cand2_vld && !starved) ? src_to_cmd(cand2) : FC_NO_CMD;
    snap_ptlp2 = (cand2_vld && !starved) ? len_sel(cand2, len_p_i, len_np_i, len_cpl_i) : '0;
  end

  always_comb begin
    logic                  win;
    logic [1:0]            win_src;
    logic [PTLP_WIDTH-1:0] win_ptlp;
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    winner_d     = winner_q;
    starve_cnt_d = starve_cnt_q;
    grant_d      = grant_q;
    cmd1_d       = cmd1_q;
    cmd2_d       = cmd2_q;
    ptlp1_d      = ptlp1_q;
    ptlp2_d      = ptlp2_q;
    upd_d        = 1'b0;
    upd_cmd_d    = FC_NO_CMD;
    upd_ptlp_d   = '0;
    win          = 1'b0;
    win_src      = SRC_P;
    win_ptlp     = '0;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          cmd1_d  = snap_cmd1;
          ptlp1_d = snap_ptlp1;
          cmd2_d  = snap_cmd2;
          ptlp2_d = snap_ptlp2;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Winner is taken from the registered offer the checker actually saw.
        if (fc_result_i == FC_SUCCESS_1 && cmd1_q != FC_NO_CMD) begin
          win          = 1'b1;
          win_src      = cmd1_q;
          win_ptlp     = ptlp1_q;
          starve_cnt_d = '0;
        end else if (fc_result_i == FC_SUCCESS_2 && cmd2_q != FC_NO_CMD) begin
          win      = 1'b1;
          win_src  = cmd2_q;
          win_ptlp = ptlp2_q;
          if (starve_cnt_q != StarveMax) starve_cnt_d = starve_cnt_q + STARVE_CNT_WIDTH'(1);
        end

        if (win) begin
          state_d    = XMIT;
          winner_d   = win_src;
          grant_d    = 3'b001 << win_src;
          cmd1_d     = FC_NO_CMD;
          cmd2_d     = FC_NO_CMD;
          ptlp1_d    = '0;
          ptlp2_d    = '0;
          upd_d      = 1'b1;
          upd_cmd_d  = src_to_cmd(win_src);
          upd_ptlp_d = win_ptlp;
        end else begin
          cmd1_d  = snap_cmd1;
          ptlp1_d = snap_ptlp1;
          cmd2_d  = snap_cmd2;
          ptlp2_d = snap_ptlp2;
        end
      end
      XMIT: begin
        if (done_i[winner_q]) begin
          rr_ptr_d = src_next(winner_q);
          grant_d  = 3'b000;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= SRC_P;
      winner_q     <= SRC_P;
      starve_cnt_q <= '0;
      grant_q      <= 3'b000;
      cmd1_q       <= FC_NO_CMD;
      cmd2_q       <= FC_NO_CMD;
      ptlp1_q      <= '0;
      ptlp2_q      <= '0;
      upd_q        <= 1'b0;
      upd_cmd_q    <= FC_NO_CMD;
      upd_ptlp_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      winner_q     <= winner_d;
      starve_cnt_q <= starve_cnt_d;
      grant_q      <= grant_d;
      cmd1_q       <= cmd1_d;
      cmd2_q       <= cmd2_d;
      ptlp1_q      <= ptlp1_d;
      ptlp2_q      <= ptlp2_d;
      upd_q        <= upd_d;
      upd_cmd_q    <= upd_cmd_d;
      upd_ptlp_q   <= upd_ptlp_d;
    end
  end

  assign grant_o          = grant_q;
  assign fc_command_1_o   = cmd1_q;
  assign fc_ptlp_1_o      = ptlp1_q;
  assign fc_command_2_o   = cmd2_q;
  assign fc_ptlp_2_o      = ptlp2_q;
  assign fc_update_o      = upd_q;
  assign fc_update_cmd_o  = upd_cmd_q;
  assign fc_update_ptlp_o = upd_ptlp_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_tx_fc_arbiter_scheduler.sv
// Self-checking bench for tx_fc_arbiter_scheduler: directed scenarios followed by
// randomized transactions, compared against a transaction-level reference model.
module tb_tx_fc_arbiter_scheduler;
  import tx_fc_arbiter_scheduler_pkg::*;

  localparam int W     = 10;
  localparam int LIMIT = 4;
  localparam int NOCMD = 3;

  logic          clk  = 1'b0;
  logic          arst = 1'b0;
  logic [2:0]    req_i  = 3'b000;
  logic [2:0]    done_i = 3'b000;
  logic [W-1:0]  lens [3];
  FC_result_t    fc_res = FC_FAILED;

  logic [W-1:0]  len_p, len_np, len_cpl;
  logic [2:0]    grant_o;
  FC_command_t   cmd1, cmd2, upd_cmd;
  logic [W-1:0]  ptlp1, ptlp2, upd_ptlp;
  logic          upd, busy;

  assign len_p   = lens[0];
  assign len_np  = lens[1];
  assign len_cpl = lens[2];

  tx_fc_arbiter_scheduler #(
    .PTLP_WIDTH   (W),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk              (clk),
    .arst             (arst),
    .req_i            (req_i),
    .len_p_i          (len_p),
    .len_np_i         (len_np),
    .len_cpl_i        (len_cpl),
    .done_i           (done_i),
    .grant_o          (grant_o),
    .fc_command_1_o   (cmd1),
    .fc_ptlp_1_o      (ptlp1),
    .fc_command_2_o   (cmd2),
    .fc_ptlp_2_o      (ptlp2),
    .fc_result_i      (fc_res),
    .fc_update_o      (upd),
    .fc_update_cmd_o  (upd_cmd),
    .fc_update_ptlp_o (upd_ptlp),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: round-robin head and consecutive candidate-2 wins.
  int m_rr     = 0;
  int m_starve = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requesting sources listed from the round-robin head; second entry hidden when starved.
  function automatic void model_cands(input logic [2:0] req, output int c1, output int c2);
    int q[$];
    for (int i = 0; i < 3; i++) begin
      int s = (m_rr + i) % 3;
      if (req[s]) q.push_back(s);
    end
    c1 = (q.size() > 0) ? q[0] : -1;
    c2 = (q.size() > 1 && m_starve < LIMIT) ? q[1] : -1;
  endfunction

  task automatic check_offer(input int c1, input int c2);
    check("cmd1", 32'(cmd1), (c1 < 0) ? NOCMD : c1);
    check("ptlp1", 32'(ptlp1), (c1 < 0) ? 0 : 32'(lens[c1]));
    check("cmd2", 32'(cmd2), (c2 < 0) ? NOCMD : c2);
    check("ptlp2", 32'(ptlp2), (c2 < 0) ? 0 : 32'(lens[c2]));
  endtask

  // One transaction: raise req, fail nfail times, then answer SUCCESS_2 (use2) or
  // SUCCESS_1; a SUCCESS_2 with no second candidate is retried as SUCCESS_1.
  // The winner ends after xmit extra cycles, or an async reset hits mid-XMIT.
  task automatic run_txn(input logic [2:0] req, input int nfail, input bit use2,
                         input int xmit, input bit rst_mid);
    int  c1, c2, w;
    bit  won, win2, force1;
    req_i  = req;
    fc_res = FC_FAILED;
    step();
    won = 0; win2 = 0; force1 = 0; w = 0;
    for (int it = 0; it < nfail + 3 && !won; it++) begin
      model_cands(req_i, c1, c2);
      check("busy_check", 32'(busy), 1);
      check("grant_check", 32'(grant_o), 0);
      check("upd_check", 32'(upd), 0);
      check_offer(c1, c2);
      if (it < nfail) begin
        fc_res = FC_FAILED;
      end else if (use2 && !force1) begin
        fc_res = FC_SUCCESS_2;
        if (c2 >= 0) begin
          w = c2; won = 1; win2 = 1;
        end else begin
          force1 = 1;
        end
      end else begin
        fc_res = FC_SUCCESS_1;
        w = c1; won = 1;
      end
      step();
    end
    fc_res = FC_FAILED;
    if (!won) begin
      check("no_win", 0, 1);
      return;
    end
    m_starve = win2 ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;

    check("grant", 32'(grant_o), 32'(1) << w);
    check("upd", 32'(upd), 1);
    check("upd_cmd", 32'(upd_cmd), w);
    check("upd_ptlp", 32'(upd_ptlp), 32'(lens[w]));
    check("cmd1_xmit", 32'(cmd1), NOCMD);
    check("cmd2_xmit", 32'(cmd2), NOCMD);
    check("busy_xmit", 32'(busy), 1);

    if (rst_mid) begin
      #2 arst = 1'b0;
      #1;
      check("rst_grant", 32'(grant_o), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_upd", 32'(upd), 0);
      check("rst_cmd1", 32'(cmd1), NOCMD);
      check("rst_upd_cmd", 32'(upd_cmd), NOCMD);
      m_rr     = 0;
      m_starve = 0;
      req_i    = 3'b000;
      @(negedge clk);
      arst = 1'b1;
      step();
      return;
    end

    for (int k = 0; k <= xmit; k++) begin
      if (k == xmit) done_i = 3'b001 << w;
      else           done_i = 3'($urandom) & ~(3'b001 << w);
      step();
      if (k < xmit) begin
        check("grant_hold", 32'(grant_o), 32'(1) << w);
        check("upd_once", 32'(upd), 0);
      end
    end
    done_i   = 3'b000;
    req_i[w] = 1'b0;
    m_rr     = (w + 1) % 3;
    check("grant_drop", 32'(grant_o), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    logic [2:0] nreq;
    for (int i = 0; i < 3; i++) lens[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_grant", 32'(grant_o), 0);
    check("reset_cmd1", 32'(cmd1), NOCMD);
    check("reset_cmd2", 32'(cmd2), NOCMD);
    check("reset_ptlp1", 32'(ptlp1), 0);
    check("reset_ptlp2", 32'(ptlp2), 0);
    check("reset_upd", 32'(upd), 0);
    check("reset_upd_cmd", 32'(upd_cmd), NOCMD);
    check("reset_upd_ptlp", 32'(upd_ptlp), 0);
    check("reset_busy", 32'(busy), 0);
    @(negedge clk);
    arst = 1'b1;
    step();

    // All three request; P wins, then NP/CPL are next
    lens[0] = 10'd5; lens[1] = 10'd17; lens[2] = 10'd200;
    run_txn(3'b111, 0, 0, 1, 0);
    run_txn(3'b110, 0, 0, 0, 0);
    run_txn(3'b100, 0, 0, 0, 0);

    // CPL alone with 32 DW payload
    lens[2] = 10'd32;
    run_txn(3'b100, 0, 0, 2, 0);

    // P+NP: three failures then SUCCESS_2, NP granted
    lens[0] = 10'd64; lens[1] = 10'd1;
    run_txn(3'b011, 3, 1, 1, 0);
    // NP keeps overtaking P until the limiter hides it
    run_txn(3'b011, 0, 1, 0, 0);
    run_txn(3'b011, 0, 1, 0, 0);
    run_txn(3'b011, 0, 1, 0, 0);
    run_txn(3'b011, 1, 1, 0, 0);
    run_txn(3'b011, 0, 1, 0, 0);

    // SUCCESS_2 with a single requester
    run_txn(3'b010, 0, 1, 0, 0);

    // Async reset in XMIT with CPL granted, then resume from P
    lens[2] = 10'd99;
    run_txn(3'b100, 0, 0, 0, 1);
    run_txn(3'b111, 0, 0, 0, 0);
    run_txn(3'b110, 0, 0, 0, 0);
    run_txn(3'b100, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      nreq = req_i | 3'($urandom_range(1, 7));
      for (int s = 0; s < 3; s++) begin
        if (nreq[s] && !req_i[s]) lens[s] = W'($urandom_range(0, 1023));
      end
      run_txn(nreq, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
